// File: rtl/i2c_write_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_write_arbiter
//
// Arbitrates two requesters onto one I2C write engine. A winner is chosen
// round-robin when the engine is idle; its address byte and 16-bit payload
// are latched and launched with a one-cycle send strobe. Completion is the
// next rising edge of the engine's done signal, or a timeout if no such edge
// arrives within TIMEOUT_CYC cycles of entering WAIT_DONE.
//
// Ports
//   i_clk, i_rst_n         clock, synchronous active-low reset
//   i_req0/1               level requests (held until the matching o_ack)
//   i_addr0/1, i_data0/1   address byte (R/W included) and write payload
//   o_gnt[1:0]             one-hot grant, held from launch through RELEASE
//   o_ack[1:0]             one-cycle completion pulse for the winner
//   o_err                  timeout flag, meaningful only while o_ack != 0
//   o_eng_send             one-cycle launch strobe to the engine
//   o_eng_addr, o_eng_data latched transfer for the engine
//   i_eng_busy, i_eng_done engine status (done may stay high for long)
//   o_busy                 high whenever the arbiter is not in IDLE
// ---------------------------------------------------------------------------
module i2c_write_arbiter #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd60000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic [7:0]  i_addr0,
  input  logic [7:0]  i_addr1,
  input  logic [15:0] i_data0,
  input  logic [15:0] i_data1,
  output logic [1:0]  o_gnt,
  output logic [1:0]  o_ack,
  output logic        o_err,
  output logic        o_eng_send,
  output logic [7:0]  o_eng_addr,
  output logic [15:0] o_eng_data,
  input  logic        i_eng_busy,
  input  logic        i_eng_done,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        win_q, win_d;     // 0 = requester 0 owns the transfer, 1 = requester 1
  logic        last_q;           // requester granted most recently
  logic        err_q, err_d;
  logic [15:0] cnt_q;
  logic        done_q;           // previous-cycle copy of i_eng_done
  logic [1:0]  gnt_q;
  logic [7:0]  addr_q;
  logic [15:0] data_q;

  logic done_rise;
  logic timeout_hit;

  // A done level that was already high when WAIT_DONE was entered has
  // done_q=1 and therefore never looks like an edge.
  assign done_rise   = i_eng_done & ~done_q;
  assign timeout_hit = (cnt_q == TIMEOUT_CYC - 16'd1);

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (!i_eng_busy && (i_req0 || i_req1)) begin
          state_d = LAUNCH;
          // With both requesting, the one not granted last goes next.
          if (i_req0 && i_req1) win_d = ~last_q;
          else                  win_d = i_req1;
        end
      end
      LAUNCH: begin
        state_d = WAIT_DONE;
        err_d   = 1'b0;
      end
      WAIT_DONE: begin
        // Done is tested first so it wins a tie with the timeout.
        if (done_rise) begin
          state_d = RELEASE;
          err_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d = RELEASE;
          err_d   = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge i_clk) begin
    // NOTE: reset is synchronous; the transfer registers are cleared too so
    // an aborted transfer leaves nothing stale on the engine bus.
    if (!i_rst_n) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;   // "requester 1 went last" gives requester 0 priority
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
      done_q  <= 1'b0;
      gnt_q   <= 2'b00;
      addr_q  <= 8'd0;
      data_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      err_q   <= err_d;
      done_q  <= i_eng_done;

      if (state_q == LAUNCH)         cnt_q <= 16'd0;
      else if (state_q == WAIT_DONE) cnt_q <= cnt_q + 16'd1;

      if (state_q == IDLE && state_d == LAUNCH) begin
        gnt_q  <= win_d ? 2'b10 : 2'b01;
        addr_q <= win_d ? i_addr1 : i_addr0;
        data_q <= win_d ? i_data1 : i_data0;
      end

      if (state_q == RELEASE) begin
        gnt_q  <= 2'b00;
        last_q <= win_q;
      end
    end
  end

  assign o_gnt      = gnt_q;
  assign o_eng_addr = addr_q;
  assign o_eng_data = data_q;
  assign o_eng_send = (state_q == LAUNCH);
  assign o_busy     = (state_q != IDLE);
  assign o_ack      = (state_q == RELEASE) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
  assign o_err      = (state_q == RELEASE) & err_q;

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_write_arbiter
//
// Scoreboard bench. Stimulus tasks decide, from the arbitration rules, who
// must win each transfer and when it must complete, and push the expected
// launch and completion into queues. A negedge monitor pops and compares
// whenever the DUT shows o_eng_send or o_ack. Inputs change #1 after posedge.
// ---------------------------------------------------------------------------
module tb_i2c_write_arbiter;

  localparam logic [15:0] TMO = 16'd600;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req0, i_req1;
  logic [7:0]  i_addr0, i_addr1;
  logic [15:0] i_data0, i_data1;
  logic [1:0]  o_gnt, o_ack;
  logic        o_err, o_eng_send, o_busy;
  logic [7:0]  o_eng_addr;
  logic [15:0] o_eng_data;
  logic        i_eng_busy, i_eng_done;

  i2c_write_arbiter #(.TIMEOUT_CYC(TMO)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req0     (i_req0),
    .i_req1     (i_req1),
    .i_addr0    (i_addr0),
    .i_addr1    (i_addr1),
    .i_data0    (i_data0),
    .i_data1    (i_data1),
    .o_gnt      (o_gnt),
    .o_ack      (o_ack),
    .o_err      (o_err),
    .o_eng_send (o_eng_send),
    .o_eng_addr (o_eng_addr),
    .o_eng_data (o_eng_data),
    .i_eng_busy (i_eng_busy),
    .i_eng_done (i_eng_done),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  who;
    logic [7:0]  addr;
    logic [15:0] data;
    int          cyc;    // -1: launch cycle not checked
  } send_t;

  typedef struct {
    logic [1:0]  who;
    logic        err;
    logic [7:0]  addr;
    logic [15:0] data;
    int          cyc;
  } ack_t;

  send_t send_q[$];
  ack_t  ack_q[$];

  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  logic last_one;        // model: 1 when requester 1 was granted last

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Round-robin rule: a lone requester wins; with both, the other one than last.
  function automatic logic [1:0] pick(input logic [1:0] m);
    if (m == 2'b01 || m == 2'b10) return m;
    return last_one ? 2'b01 : 2'b10;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (o_eng_send) begin
        if (send_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_send: addr=%0h data=%0h gnt=%0b", o_eng_addr, o_eng_data, o_gnt);
        end else begin
          send_t s;
          s = send_q.pop_front();
          check("send_gnt", 32'(o_gnt), 32'(s.who));
          check("send_addr", 32'(o_eng_addr), 32'(s.addr));
          check("send_data", 32'(o_eng_data), 32'(s.data));
          if (s.cyc >= 0) check("send_cycle", cyc, s.cyc);
        end
      end
      if (o_ack != 2'b00) begin
        if (ack_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: ack=%0b err=%0b", o_ack, o_err);
        end else begin
          ack_t a;
          a = ack_q.pop_front();
          check("ack_who", 32'(o_ack), 32'(a.who));
          check("ack_err", 32'(o_err), 32'(a.err));
          check("ack_cycle", cyc, a.cyc);
          check("ack_gnt_held", 32'(o_gnt), 32'(a.who));
          check("ack_addr_held", 32'(o_eng_addr), 32'(a.addr));
          check("ack_data_held", 32'(o_eng_data), 32'(a.data));
        end
      end else if (o_err) begin
        total++; bad++;
        $display("FAIL err_without_ack: err=1 ack=0");
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_send(output int s);
    s = -1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge i_clk);
      if (o_eng_send) begin
        s = cyc;
        break;
      end
    end
    if (s < 0) begin
      total++; bad++;
      $display("FAIL wait_send: no o_eng_send within 3000 cycles");
    end
  endtask

  task automatic wait_ack(output int a);
    a = -1;
    for (int n = 0; n < int'(TMO) + 200; n++) begin
      @(negedge i_clk);
      if (o_ack != 2'b00) begin
        a = cyc;
        break;
      end
    end
    if (a < 0) begin
      total++; bad++;
      $display("FAIL wait_ack: no o_ack within bound");
    end
  endtask

  // One transfer owned by 'who'. d>0: engine raises done d cycles after the
  // launch cycle; d<0: engine never completes, a timeout is expected.
  task automatic run_one(input logic [1:0] who, input int scyc, input int d, output int acyc);
    int          s;
    logic [7:0]  a;
    logic [15:0] dt;
    a  = who[1] ? i_addr1 : i_addr0;
    dt = who[1] ? i_data1 : i_data0;
    send_q.push_back('{who: who, addr: a, data: dt, cyc: scyc});
    acyc = -1;
    wait_send(s);
    if (s < 0) return;
    // The latched transfer must not follow later input changes.
    if (who[1]) begin i_addr1 = 8'($urandom); i_data1 = 16'($urandom); end
    else        begin i_addr0 = 8'($urandom); i_data0 = 16'($urandom); end
    if (d < 0) begin
      ack_q.push_back('{who: who, err: 1'b1, addr: a, data: dt, cyc: s + 1 + int'(TMO)});
    end else begin
      repeat (d) @(posedge i_clk);
      #1;
      ack_q.push_back('{who: who, err: 1'b0, addr: a, data: dt, cyc: cyc + 1});
      i_eng_done = 1'b1;
    end
    wait_ack(acyc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},  32'(o_gnt), 0);
    check({tag, "_ack"},  32'(o_ack), 0);
    check({tag, "_err"},  32'(o_err), 0);
    check({tag, "_send"}, 32'(o_eng_send), 0);
    check({tag, "_busy"}, 32'(o_busy), 0);
    check({tag, "_addr"}, 32'(o_eng_addr), 0);
    check({tag, "_data"}, 32'(o_eng_data), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int   a, s;
    logic [1:0] who;
    bit   pend [2];

    i_rst_n = 1'b0; i_req0 = 1'b0; i_req1 = 1'b0;
    i_addr0 = 8'h00; i_addr1 = 8'h00; i_data0 = 16'h0; i_data1 = 16'h0;
    i_eng_busy = 1'b0; i_eng_done = 1'b0;
    last_one = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_all_zero("reset");
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    mon_en  = 1'b1;

    // Contention, both held through their acks: order 0,1,0,1.
    i_addr0 = 8'hA0; i_data0 = 16'h1111; i_addr1 = 8'hB2; i_data1 = 16'h2222;
    i_req0 = 1'b1; i_req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      who = pick(2'b11);
      check("rr_order", 32'(who), (k % 2 == 0) ? 32'd1 : 32'd2);
      last_one = who[1];
      run_one(who, (k == 0) ? cyc + 1 : -1, $urandom_range(1, 20), a);
      @(posedge i_clk); #1;
      i_eng_done = 1'b0;
      if (k == 3) begin i_req0 = 1'b0; i_req1 = 1'b0; end
    end

    // Single request, done after 500 cycles and then held high a while.
    repeat (3) @(posedge i_clk); #1;
    i_addr0 = 8'h90; i_data0 = 16'hA55A; i_req0 = 1'b1;
    last_one = 1'b0;
    run_one(2'b01, cyc + 1, 500, a);
    @(posedge i_clk); #1;
    i_req0 = 1'b0;
    @(negedge i_clk);
    check("single_busy_after", 32'(o_busy), 0);
    repeat (5) @(posedge i_clk); #1;
    i_eng_done = 1'b0;

    // Timeout: engine never completes.
    repeat (2) @(posedge i_clk); #1;
    i_addr1 = 8'h5C; i_data1 = 16'hBEEF; i_req1 = 1'b1;
    last_one = 1'b1;
    run_one(2'b10, cyc + 1, -1, a);
    @(posedge i_clk); #1;
    i_req1 = 1'b0;
    @(negedge i_clk);
    check("timeout_idle", 32'(o_busy), 0);

    // Stale done: high before launch; completes only on a fresh edge.
    @(posedge i_clk); #1;
    i_eng_done = 1'b1;
    repeat (3) @(posedge i_clk); #1;
    i_addr0 = 8'h22; i_data0 = 16'h0F0F; i_req0 = 1'b1;
    last_one = 1'b0;
    send_q.push_back('{who: 2'b01, addr: 8'h22, data: 16'h0F0F, cyc: cyc + 1});
    wait_send(s);
    repeat (30) @(posedge i_clk); #1;
    i_eng_done = 1'b0;
    @(posedge i_clk); #1;
    ack_q.push_back('{who: 2'b01, err: 1'b0, addr: 8'h22, data: 16'h0F0F, cyc: cyc + 1});
    i_eng_done = 1'b1;
    wait_ack(a);
    @(posedge i_clk); #1;
    i_req0 = 1'b0;
    // Stale level that never falls ends in a timeout.
    repeat (3) @(posedge i_clk); #1;
    i_req0 = 1'b1;
    run_one(2'b01, cyc + 1, -1, a);
    @(posedge i_clk); #1;
    i_req0 = 1'b0; i_eng_done = 1'b0;

    // Busy gating: no grant or launch while the engine reports busy.
    repeat (2) @(posedge i_clk); #1;
    i_eng_busy = 1'b1;
    i_addr1 = 8'h74; i_data1 = 16'h7777; i_req1 = 1'b1;
    repeat (20) @(posedge i_clk);
    @(negedge i_clk);
    check("busy_gate_gnt", 32'(o_gnt), 0);
    check("busy_gate_busy", 32'(o_busy), 0);
    @(posedge i_clk); #1;
    i_eng_busy = 1'b0;
    last_one = 1'b1;
    run_one(2'b10, cyc + 1, 7, a);
    @(posedge i_clk); #1;
    i_req1 = 1'b0; i_eng_done = 1'b0;

    // Reset in the middle of WAIT_DONE aborts without an ack.
    repeat (2) @(posedge i_clk); #1;
    i_addr0 = 8'h3E; i_data0 = 16'hC0DE; i_req0 = 1'b1;
    send_q.push_back('{who: 2'b01, addr: 8'h3E, data: 16'hC0DE, cyc: cyc + 1});
    wait_send(s);
    repeat (10) @(posedge i_clk); #1;
    i_rst_n = 1'b0; i_req0 = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    last_one = 1'b1;
    @(negedge i_clk);
    check_all_zero("midreset");
    repeat (50) @(posedge i_clk); #1;
    i_addr0 = 8'h3F; i_data0 = 16'h1234; i_req0 = 1'b1;
    last_one = 1'b0;
    run_one(2'b01, cyc + 1, 12, a);
    @(posedge i_clk); #1;
    i_req0 = 1'b0; i_eng_done = 1'b0;

    // Randomized traffic against a pending-set round-robin model.
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int r = 0; r < 16; r++) begin
      logic [1:0] m;
      int         d;
      if (!pend[0] && $urandom_range(0, 1) == 1) begin
        pend[0] = 1'b1; i_addr0 = 8'($urandom); i_data0 = 16'($urandom); i_req0 = 1'b1;
      end
      if (!pend[1] && $urandom_range(0, 1) == 1) begin
        pend[1] = 1'b1; i_addr1 = 8'($urandom); i_data1 = 16'($urandom); i_req1 = 1'b1;
      end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1'b1; i_addr0 = 8'($urandom); i_data0 = 16'($urandom); i_req0 = 1'b1;
      end
      m   = {pend[1], pend[0]};
      who = pick(m);
      last_one = who[1];
      d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 40));
      run_one(who, -1, d, a);
      @(posedge i_clk); #1;
      i_eng_done = 1'b0;
      if (who[1]) begin i_req1 = 1'b0; pend[1] = 1'b0; end
      else        begin i_req0 = 1'b0; pend[0] = 1'b0; end
    end
    // Serve anything still pending so the bench ends idle.
    if (pend[0] || pend[1]) begin
      who = pend[1] ? 2'b10 : 2'b01;
      last_one = who[1];
      run_one(who, -1, 5, a);
      @(posedge i_clk); #1;
      i_eng_done = 1'b0; i_req0 = 1'b0; i_req1 = 1'b0;
    end

    repeat (10) @(posedge i_clk);
    @(negedge i_clk);
    check("end_send_q_empty", send_q.size(), 0);
    check("end_ack_q_empty", ack_q.size(), 0);
    check("end_idle", 32'(o_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
